axis_pkt_fifo: RTL and testbench

- Store-and-forward AXI-Stream FIFO placed directly downstream of each master port of the round-robin AXI-Stream switch.
- It absorbs the switch's per-master output stream and re-emits it unchanged.
- In packet mode it only presents a packet once its last beat is buffered, so a slow producer cannot stall the consumer mid-packet.
- A forced-release mechanism prevents deadlock on packets longer than the buffer.

---
 rtl/axis_pkt_fifo.sv | 113 +++++++++++
 tb/tb_axis_pkt_fifo.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream FIFO with a packet gate on tlast and a forced
// cut-through release for packets larger than the buffer.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEST_WIDTH  = 1,
  parameter int ID_WIDTH    = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic [DEST_WIDTH-1:0]        s_dest,
  input  logic [ID_WIDTH-1:0]          s_id,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [DEST_WIDTH-1:0]        m_dest,
  output logic [ID_WIDTH-1:0]          m_id,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = DATA_WIDTH + DEST_WIDTH + ID_WIDTH + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pkt;
  logic          r_release;
  logic          r_init;

  logic          w_full;
  logic          w_nonempty;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_last;
  logic          w_rd_last;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

  // r_init holds s_ready low until the first edge after reset is released.
  assign s_ready   = r_init && !w_full;
  assign w_wr      = s_valid && s_ready;
  assign w_rd      = m_valid && m_ready;
  assign w_wr_last = w_wr && s_last;
  assign w_rd_last = w_rd && m_last;

  assign {m_data, m_dest, m_id, m_last} = r_mem[r_rptr];
  assign count     = r_count;
  assign pkt_count = r_pkt;

  if (PACKET_MODE != 0) begin : g_pkt
    assign m_valid = w_nonempty && ((r_pkt != '0) || r_release);
  end else begin : g_plain
    assign m_valid = w_nonempty;
  end

  // Payload storage carries no reset; only the control state below does.
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {s_data, s_dest, s_id, s_last};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_init    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pkt     <= '0;
      r_release <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end

      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case ({w_wr_last, w_rd_last})
        2'b10:   r_pkt <= r_pkt + CW'(1);
        2'b01:   r_pkt <= r_pkt - CW'(1);
        default: r_pkt <= r_pkt;
      endcase

      // A full buffer with no complete packet can never drain on its own,
      // so open the gate until that oversize packet's last beat leaves.
      if (w_rd_last) begin
        r_release <= 1'b0;
      end else if (w_full && (r_pkt == '0)) begin
        r_release <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a plain-mode and a packet-mode instance checked
// every cycle against a queue-based model, plus directed corner sequences.
module tb_axis_pkt_fifo;

  localparam int DW    = 64;
  localparam int TW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] dest;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       l;
    logic       mr;
    logic       e_mv;
    logic [7:0] e_d;
    logic       e_l;
    int         e_cnt;
    int         e_pk;
  } vec_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic          s_valid [2];
  logic          s_ready [2];
  logic [DW-1:0] s_data  [2];
  logic [TW-1:0] s_dest  [2];
  logic [IW-1:0] s_id    [2];
  logic          s_last  [2];
  logic          m_valid [2];
  logic          m_ready [2];
  logic [DW-1:0] m_data  [2];
  logic [TW-1:0] m_dest  [2];
  logic [IW-1:0] m_id    [2];
  logic          m_last  [2];
  logic [CW-1:0] count     [2];
  logic [CW-1:0] pkt_count [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .ID_WIDTH(IW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_plain (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_dest(s_dest[0]),
    .s_id(s_id[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_dest(m_dest[0]),
    .m_id(m_id[0]), .m_last(m_last[0]),
    .count(count[0]), .pkt_count(pkt_count[0])
  );

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .ID_WIDTH(IW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pkt (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_dest(s_dest[1]),
    .s_id(s_id[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_dest(m_dest[1]),
    .m_id(m_id[1]), .m_last(m_last[1]),
    .count(count[1]), .pkt_count(pkt_count[1])
  );

  // Reference model: the stored beats as a queue per instance.
  beat_t q0[$];
  beat_t q1[$];
  bit    rel1;
  bit    init;

  function automatic int qsize(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int nlast(int m);
    int n = 0;
    if (m == 0) begin
      foreach (q0[i]) if (q0[i].last) n++;
    end else begin
      foreach (q1[i]) if (q1[i].last) n++;
    end
    return n;
  endfunction

  function automatic bit exp_sr(int m);
    return init && (qsize(m) < DEPTH);
  endfunction

  function automatic bit exp_mv(int m);
    if (qsize(m) == 0) return 1'b0;
    if (m == 0) return 1'b1;
    return (nlast(1) != 0) || rel1;
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    rel1 = 1'b0;
    init = 1'b0;
  endtask

  task automatic model_step();
    bit    wr [2];
    bit    rd [2];
    beat_t b;
    if (!aresetn) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      wr[m] = s_valid[m] && exp_sr(m);
      rd[m] = m_ready[m] && exp_mv(m);
    end
    if (rd[1] && q1[0].last) rel1 = 1'b0;
    else if (q1.size() == DEPTH && nlast(1) == 0) rel1 = 1'b1;
    if (rd[0]) void'(q0.pop_front());
    if (rd[1]) void'(q1.pop_front());
    for (int m = 0; m < 2; m++) begin
      if (wr[m]) begin
        b.d = s_data[m]; b.dest = s_dest[m]; b.id = s_id[m]; b.last = s_last[m];
        if (m == 0) q0.push_back(b); else q1.push_back(b);
      end
    end
    init = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    string p;
    beat_t h;
    for (int m = 0; m < 2; m++) begin
      p = (m == 0) ? "plain" : "pkt";
      chk({p, " s_ready"}, 64'(s_ready[m]), 64'(exp_sr(m)));
      chk({p, " m_valid"}, 64'(m_valid[m]), 64'(exp_mv(m)));
      chk({p, " count"}, 64'(count[m]), 64'(qsize(m)));
      chk({p, " pkt_count"}, 64'(pkt_count[m]), 64'(nlast(m)));
      if (exp_mv(m)) begin
        h = qfront(m);
        chk({p, " m_data"}, m_data[m], h.d);
        chk({p, " m_dest"}, 64'(m_dest[m]), 64'(h.dest));
        chk({p, " m_id"}, 64'(m_id[m]), 64'(h.id));
        chk({p, " m_last"}, 64'(m_last[m]), 64'(h.last));
      end
    end
  endtask

  task automatic at_neg();
    @(negedge aclk);
    compare_all();
  endtask

  task automatic at_pos();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      s_valid[m] = 1'b0; s_last[m] = 1'b0; m_ready[m] = 1'b0;
      s_data[m] = '0; s_dest[m] = '0; s_id[m] = '0;
    end
  endtask

  task automatic do_reset();
    idle_all();
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    model_clear();
    at_neg();
    at_pos();
    aresetn = 1'b1;
    at_neg();
    at_pos();
  endtask

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, got, c;
    bit saw_full, pend;
    bit acc [2];

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1, 0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1, 0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1, 1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0};

    idle_all();
    model_clear();

    // Plain-mode three-beat table on the PACKET_MODE=0 instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid[0] = tbl[i].sv; s_data[0] = 64'(tbl[i].d); s_last[0] = tbl[i].l; m_ready[0] = tbl[i].mr;
      at_neg();
      chk($sformatf("tbl%0d s_ready", i), 64'(s_ready[0]), 64'd1);
      chk($sformatf("tbl%0d m_valid", i), 64'(m_valid[0]), 64'(tbl[i].e_mv));
      chk($sformatf("tbl%0d count", i), 64'(count[0]), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d pkt_count", i), 64'(pkt_count[0]), 64'(tbl[i].e_pk));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d m_data", i), m_data[0], 64'(tbl[i].e_d));
        chk($sformatf("tbl%0d m_last", i), 64'(m_last[0]), 64'(tbl[i].e_l));
      end
      at_pos();
    end

    // Packet gate: four beats with idle gaps, nothing shown until the last.
    do_reset();
    m_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid[1] = 1'b1; s_data[1] = 64'hA0 + 64'(i); s_last[1] = (i == 3);
      at_neg();
      chk("pm gated m_valid", 64'(m_valid[1]), 64'd0);
      at_pos();
      s_valid[1] = 1'b0; s_last[1] = 1'b0;
      at_neg();
      chk("pm m_valid after write", 64'(m_valid[1]), 64'(i == 3));
      chk("pm pkt_count", 64'(pkt_count[1]), 64'(i == 3));
      if (i == 3) chk("pm first beat", m_data[1], 64'hA0);
      at_pos();
    end
    for (int j = 1; j < 4; j++) begin
      at_neg();
      chk("pm contiguous m_valid", 64'(m_valid[1]), 64'd1);
      chk("pm beat order", m_data[1], 64'hA0 + 64'(j));
      at_pos();
    end
    at_neg();
    chk("pm drained m_valid", 64'(m_valid[1]), 64'd0);
    chk("pm drained pkt_count", 64'(pkt_count[1]), 64'd0);
    at_pos();

    // Fill with 20 single-beat packets while the sink stalls.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      for (int m = 0; m < 2; m++) begin
        s_valid[m] = 1'b1; s_last[m] = 1'b1; s_data[m] = 64'(i);
      end
      at_neg();
      if (i == 15) begin
        chk("fill s_ready at DEPTH-1", 64'(s_ready[0]), 64'd1);
        chk("fill count at DEPTH-1", 64'(count[0]), 64'd15);
      end
      if (i == 16) begin
        chk("fill plain s_ready", 64'(s_ready[0]), 64'd0);
        chk("fill plain count", 64'(count[0]), 64'd16);
        chk("fill plain pkt_count", 64'(pkt_count[0]), 64'd16);
        chk("fill pkt s_ready", 64'(s_ready[1]), 64'd0);
        chk("fill pkt pkt_count", 64'(pkt_count[1]), 64'd16);
      end
      at_pos();
    end
    for (int m = 0; m < 2; m++) begin
      s_valid[m] = 1'b0; m_ready[m] = 1'b1;
    end
    at_neg();
    chk("full read cycle s_ready", 64'(s_ready[0]), 64'd0);
    at_pos();
    at_neg();
    chk("after read s_ready", 64'(s_ready[0]), 64'd1);
    chk("after read count", 64'(count[0]), 64'd15);
    at_pos();
    for (int i = 0; i < 16; i++) tick();
    at_neg();
    chk("fill drained count", 64'(count[1]), 64'd0);
    at_pos();

    // Oversize 24-beat packet forces a release on the packet-mode instance.
    do_reset();
    m_ready[1] = 1'b1;
    idx = 0; got = 0; saw_full = 1'b0; pend = 1'b0;
    s_valid[1] = 1'b1; s_data[1] = 64'h0; s_last[1] = 1'b0;
    c = 0;
    while (c < 200 && got < 24) begin
      at_neg();
      if (pend) begin
        chk("release m_valid rises", 64'(m_valid[1]), 64'd1);
        pend = 1'b0;
      end else if (!saw_full && qsize(1) == DEPTH) begin
        saw_full = 1'b1;
        pend = 1'b1;
        chk("release gated at full", 64'(m_valid[1]), 64'd0);
        chk("release pkt_count at full", 64'(pkt_count[1]), 64'd0);
      end
      if (m_valid[1] && m_ready[1]) begin
        chk("release beat order", m_data[1], 64'(got));
        got++;
      end
      acc[1] = s_valid[1] && exp_sr(1);
      at_pos();
      if (acc[1]) begin
        idx++;
        if (idx < 24) begin
          s_data[1] = 64'(idx); s_last[1] = (idx == 23);
        end else begin
          s_valid[1] = 1'b0; s_last[1] = 1'b0;
        end
      end
      c++;
    end
    chk("release saw full", 64'(saw_full), 64'd1);
    chk("release all beats", 64'(got), 64'd24);
    s_valid[1] = 1'b1; s_data[1] = 64'h99; s_last[1] = 1'b0;
    tick();
    s_valid[1] = 1'b0;
    at_neg();
    chk("release cleared gate", 64'(m_valid[1]), 64'd0);
    at_pos();

    // Simultaneous last write and last read at count=5, pkt_count=2.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid[1] = 1'b1; s_data[1] = 64'hB0 + 64'(i); s_last[1] = (i < 2);
      tick();
    end
    s_valid[1] = 1'b1; s_data[1] = 64'hBF; s_last[1] = 1'b1; m_ready[1] = 1'b1;
    at_neg();
    chk("sim before count", 64'(count[1]), 64'd5);
    chk("sim before pkt_count", 64'(pkt_count[1]), 64'd2);
    chk("sim head last", 64'(m_last[1]), 64'd1);
    at_pos();
    s_valid[1] = 1'b0; s_last[1] = 1'b0; m_ready[1] = 1'b0;
    at_neg();
    chk("sim after count", 64'(count[1]), 64'd5);
    chk("sim after pkt_count", 64'(pkt_count[1]), 64'd2);
    at_pos();

    // Asynchronous reset with seven beats of a partial packet stored.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      for (int m = 0; m < 2; m++) begin
        s_valid[m] = 1'b1; s_data[m] = 64'hC0 + 64'(i); s_last[m] = 1'b0;
      end
      tick();
    end
    for (int m = 0; m < 2; m++) s_valid[m] = 1'b0;
    #2;
    aresetn = 1'b0;
    model_clear();
    #1;
    chk("async rst plain m_valid", 64'(m_valid[0]), 64'd0);
    chk("async rst plain s_ready", 64'(s_ready[0]), 64'd0);
    chk("async rst pkt s_ready", 64'(s_ready[1]), 64'd0);
    chk("async rst plain count", 64'(count[0]), 64'd0);
    chk("async rst pkt count", 64'(count[1]), 64'd0);
    at_neg();
    at_pos();
    aresetn = 1'b1;
    tick();
    m_ready[1] = 1'b1;
    idx = 0; got = 0; c = 0;
    s_valid[1] = 1'b1; s_data[1] = 64'hD0; s_last[1] = 1'b0;
    while (c < 40 && got < 3) begin
      at_neg();
      if (m_valid[1] && m_ready[1]) begin
        chk("post-reset beat", m_data[1], 64'hD0 + 64'(got));
        got++;
      end
      acc[1] = s_valid[1] && exp_sr(1);
      at_pos();
      if (acc[1]) begin
        idx++;
        if (idx < 3) begin
          s_data[1] = 64'hD0 + 64'(idx); s_last[1] = (idx == 2);
        end else begin
          s_valid[1] = 1'b0; s_last[1] = 1'b0;
        end
      end
      c++;
    end
    chk("post-reset packet beats", 64'(got), 64'd3);

    // Randomized traffic on both instances against the model.
    do_reset();
    for (int cyc = 0; cyc < 2400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!s_valid[m] && $urandom_range(3) != 0) begin
          s_valid[m] = 1'b1;
          s_data[m]  = {$urandom, $urandom};
          s_dest[m]  = TW'($urandom);
          s_id[m]    = IW'($urandom);
          s_last[m]  = ((cyc / 200) % 3 == 2) ? ($urandom_range(39) == 0) : ($urandom_range(4) == 0);
        end
        m_ready[m] = ((cyc / 200) % 2 == 1) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
      end
      at_neg();
      for (int m = 0; m < 2; m++) acc[m] = s_valid[m] && exp_sr(m);
      at_pos();
      for (int m = 0; m < 2; m++) if (acc[m]) s_valid[m] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
